// File: rtl/dmem_pkg.sv
// Shared constants for the CPU data-port responder: MMIO register map and STATUS layout.
package dmem_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BYTE_W = 8;

   localparam logic [11:0] OFF_CYCLE  = 12'h000;
   localparam logic [11:0] OFF_TXDATA = 12'h004;
   localparam logic [11:0] OFF_STATUS = 12'h008;

   localparam int unsigned ST_FULL  = 0;
   localparam int unsigned ST_EMPTY = 1;
   localparam int unsigned ST_OVF   = 2;

   typedef enum logic [1:0] {
      REG_CYCLE  = 2'd0,
      REG_TXDATA = 2'd1,
      REG_STATUS = 2'd2,
      REG_NONE   = 2'd3
   } mmio_reg_e;

   // Word offset (byte offset bits [11:2]) to register select; byte lanes are ignored.
   function automatic mmio_reg_e decode_reg(input logic [9:0] word_off);
      mmio_reg_e sel;
      sel = REG_NONE;
      if (word_off == OFF_CYCLE[11:2])
         sel = REG_CYCLE;
      else if (word_off == OFF_TXDATA[11:2])
         sel = REG_TXDATA;
      else if (word_off == OFF_STATUS[11:2])
         sel = REG_STATUS;
      return sel;
   endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO feeding the TX stream; head byte is presented directly from storage (no bypass).
module tx_fifo #(
   parameter int unsigned TX_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        push,
   input  logic [7:0]                  din,
   input  logic                        pop,
   output logic [7:0]                  dout,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(TX_DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(TX_DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [7:0]    storage [TX_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   // A push into a full FIFO only lands when a pop frees the slot on the same edge.
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         for (int unsigned i = 0; i < TX_DEPTH; i++)
            storage[i] <= '0;
      end else begin
         if (do_push) begin
            storage[wr_ptr] <= din;
            wr_ptr          <= wr_ptr + PW'(1);
         end
         if (do_pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign dout  = storage[rd_ptr];
   assign full  = (count_q == CW'(TX_DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/dmem_responder.sv
// CPU data-port responder: word RAM with combinational read, plus MMIO cycle counter,
// TX byte FIFO and status register.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH     = 1024,
   parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
   parameter int unsigned TX_DEPTH  = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] Mem_WrAddr,
   input  logic [31:0] Mem_WrData,
   output logic [31:0] ReadData,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(TX_DEPTH) + 1;

   logic [DATA_W-1:0] ram [DEPTH];
   logic [AW-1:0]     ram_idx;
   logic              mmio_sel;
   mmio_reg_e         reg_sel;

   logic [DATA_W-1:0] cycle_q;
   logic              overflow_q;

   logic              wr_cycle;
   logic              push;
   logic              pop;
   logic              clr_ovf;
   logic              set_ovf;

   logic              fifo_full;
   logic              fifo_empty;
   logic [BYTE_W-1:0] fifo_dout;
   logic [CW-1:0]     fifo_count;
   logic [DATA_W-1:0] status;
   logic              unused_ok;

   // Address decode; upper RAM address bits alias so out-of-range words wrap.
   assign mmio_sel = (Mem_WrAddr[31:12] == MMIO_BASE[31:12]);
   assign ram_idx  = Mem_WrAddr[AW+1:2];
   assign reg_sel  = decode_reg(Mem_WrAddr[11:2]);

   assign wr_cycle = MemWrite & mmio_sel & (reg_sel == REG_CYCLE);
   assign push     = MemWrite & mmio_sel & (reg_sel == REG_TXDATA);
   assign clr_ovf  = MemWrite & mmio_sel & (reg_sel == REG_STATUS) & Mem_WrData[ST_OVF];
   assign pop      = tx_valid & tx_ready;
   assign set_ovf  = push & fifo_full & ~pop;

   // RAM contents are intentionally left unreset.
   always_ff @(posedge clk) begin
      if (MemWrite && !mmio_sel)
         ram[ram_idx] <= Mem_WrData;
   end

   // Free-running counter; a store replaces the increment on that edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cycle_q <= '0;
      else if (wr_cycle)
         cycle_q <= Mem_WrData;
      else
         cycle_q <= cycle_q + DATA_W'(1);
   end

   // Sticky overflow; a dropped byte outranks a simultaneous clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         overflow_q <= 1'b0;
      else if (set_ovf)
         overflow_q <= 1'b1;
      else if (clr_ovf)
         overflow_q <= 1'b0;
   end

   tx_fifo #(
      .TX_DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (Mem_WrData[BYTE_W-1:0]),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign tx_data  = fifo_dout;
   assign tx_valid = ~fifo_empty;

   always_comb begin
      status           = '0;
      status[ST_FULL]  = fifo_full;
      status[ST_EMPTY] = fifo_empty;
      status[ST_OVF]   = overflow_q;
   end

   // Load data mux: RAM or MMIO register, all combinational.
   always_comb begin
      ReadData = '0;
      if (!mmio_sel) begin
         ReadData = ram[ram_idx];
      end else begin
         case (reg_sel)
            REG_CYCLE:  ReadData = cycle_q;
            REG_STATUS: ReadData = status;
            default:    ReadData = '0;
         endcase
      end
   end

   assign unused_ok = ^{Mem_WrAddr[1:0], fifo_count};

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table plus hand sequences for multi-cycle cases.
module tb_dmem_responder;

   localparam int unsigned DEPTH = 1024;
   localparam logic [31:0] A_CYC = 32'h8000_0000;
   localparam logic [31:0] A_TX  = 32'h8000_0004;
   localparam logic [31:0] A_ST  = 32'h8000_0008;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemWrite;
   logic [31:0] Mem_WrAddr;
   logic [31:0] Mem_WrData;
   logic [31:0] ReadData;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   int n_total = 0;
   int n_pass  = 0;

   dmem_responder #(
      .DEPTH     (DEPTH),
      .MMIO_BASE (32'h8000_0000),
      .TX_DEPTH  (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .MemWrite   (MemWrite),
      .Mem_WrAddr (Mem_WrAddr),
      .Mem_WrData (Mem_WrData),
      .ReadData   (ReadData),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rdy;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic        exp_valid;
      logic [7:0]  exp_data;
   } vec_t;

   vec_t vecs [17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic rdy);
      MemWrite   = we;
      Mem_WrAddr = addr;
      Mem_WrData = data;
      tx_ready   = rdy;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] exp_bytes [8];

   initial begin
      vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,         1'b0, 8'h00};
      vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00};
      vecs[2]  = '{1'b0, 32'h0000_1010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00};
      vecs[3]  = '{1'b1, 32'h0000_0014, 32'h1234_5678, 1'b0, 1'b0, 32'h0,         1'b0, 8'h00};
      vecs[4]  = '{1'b0, 32'h0000_0014, 32'h0,         1'b0, 1'b1, 32'h1234_5678, 1'b0, 8'h00};
      vecs[5]  = '{1'b0, A_TX,          32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 8'h00};
      vecs[6]  = '{1'b0, 32'h8000_0010, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 8'h00};
      vecs[7]  = '{1'b1, A_TX,          32'h0000_0141, 1'b0, 1'b0, 32'h0,         1'b0, 8'h00};
      vecs[8]  = '{1'b1, A_TX,          32'h0000_0042, 1'b0, 1'b0, 32'h0,         1'b1, 8'h41};
      vecs[9]  = '{1'b1, A_TX,          32'h0000_0043, 1'b0, 1'b0, 32'h0,         1'b1, 8'h41};
      vecs[10] = '{1'b0, A_ST,          32'h0,         1'b0, 1'b1, 32'h0,         1'b1, 8'h41};
      vecs[11] = '{1'b0, A_ST,          32'h0,         1'b1, 1'b1, 32'h0,         1'b1, 8'h41};
      vecs[12] = '{1'b0, A_ST,          32'h0,         1'b1, 1'b1, 32'h0,         1'b1, 8'h42};
      vecs[13] = '{1'b0, A_ST,          32'h0,         1'b1, 1'b1, 32'h0,         1'b1, 8'h43};
      vecs[14] = '{1'b0, A_ST,          32'h0,         1'b1, 1'b1, 32'h2,         1'b0, 8'h00};
      vecs[15] = '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,         1'b0, 8'h00};
      vecs[16] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00};

      // Reset state
      reset = 1'b0;
      drive(1'b0, A_ST, 32'h0, 1'b0);
      #1;
      check("rst_tx_valid", 32'(tx_valid), 32'h0);
      check("rst_tx_data", 32'(tx_data), 32'h0);
      check("rst_status", ReadData, 32'h2);
      drive(1'b0, A_CYC, 32'h0, 1'b0);
      check("rst_cycle", ReadData, 32'h0);

      @(negedge clk);
      reset = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      drive(1'b0, A_CYC, 32'h0, 1'b0);
      check("cycle_after_5", ReadData, 32'd5);
      step();

      // Vector table
      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdy);
         if (vecs[i].chk_rd)
            check($sformatf("vec%0d_rdata", i), ReadData, vecs[i].exp_rd);
         check($sformatf("vec%0d_valid", i), 32'(tx_valid), 32'(vecs[i].exp_valid));
         check($sformatf("vec%0d_data", i), 32'(tx_data), 32'(vecs[i].exp_data));
         step();
      end

      // CYCLE load and wrap
      drive(1'b1, A_CYC, 32'hFFFF_FFFE, 1'b0);
      step();
      drive(1'b0, A_CYC, 32'h0, 1'b0);
      check("cycle_load", ReadData, 32'hFFFF_FFFE);
      step();
      drive(1'b0, A_CYC, 32'h0, 1'b0);
      check("cycle_max", ReadData, 32'hFFFF_FFFF);
      step();
      drive(1'b0, A_CYC, 32'h0, 1'b0);
      check("cycle_wrap", ReadData, 32'h0);

      // Overflow: 9 pushes into 8 entries
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, A_TX, 32'(i), 1'b0);
         step();
      end
      drive(1'b0, A_ST, 32'h0, 1'b0);
      check("ovf_status", ReadData, 32'h5);
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, A_ST, 32'h0, 1'b1);
         check($sformatf("ovf_drain%0d_valid", i), 32'(tx_valid), 32'h1);
         check($sformatf("ovf_drain%0d_data", i), 32'(tx_data), 32'(i));
         step();
      end
      drive(1'b0, A_ST, 32'h0, 1'b0);
      check("ovf_drained_valid", 32'(tx_valid), 32'h0);
      check("ovf_sticky_status", ReadData, 32'h6);
      drive(1'b1, A_ST, 32'h4, 1'b0);
      step();
      drive(1'b0, A_ST, 32'h0, 1'b0);
      check("ovf_cleared_status", ReadData, 32'h2);

      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, A_TX, 32'h10 + 32'(i), 1'b0);
         step();
      end
      drive(1'b0, A_ST, 32'h0, 1'b0);
      check("full_status", ReadData, 32'h1);
      drive(1'b1, A_TX, 32'hAA, 1'b1);
      check("full_pp_head", 32'(tx_data), 32'h10);
      step();
      drive(1'b0, A_ST, 32'h0, 1'b0);
      check("full_pp_status", ReadData, 32'h1);
      for (int i = 0; i < 7; i++)
         exp_bytes[i] = 8'h11 + 8'(i);
      exp_bytes[7] = 8'hAA;
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, A_ST, 32'h0, 1'b1);
         check($sformatf("pp_drain%0d_data", i), 32'(tx_data), 32'(exp_bytes[i]));
         step();
      end
      drive(1'b0, A_ST, 32'h0, 1'b0);
      check("pp_drained_status", ReadData, 32'h2);

      // Asynchronous reset with bytes queued
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, A_TX, 32'h61 + 32'(i), 1'b0);
         step();
      end
      drive(1'b0, A_CYC, 32'h0, 1'b0);
      check("pre_rst_valid", 32'(tx_valid), 32'h1);
      #1;
      reset = 1'b0;
      #1;
      check("async_rst_valid", 32'(tx_valid), 32'h0);
      check("async_rst_data", 32'(tx_data), 32'h0);
      check("async_rst_cycle", ReadData, 32'h0);
      step();
      check("held_rst_cycle", ReadData, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      step();
      drive(1'b0, A_CYC, 32'h0, 1'b0);
      check("post_rst_cycle", ReadData, 32'h1);
      drive(1'b0, A_ST, 32'h0, 1'b0);
      check("post_rst_status", ReadData, 32'h2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
